sync_fifo_prog: RTL and testbench

//  Parametrised single-clock FIFO. Successor to the basic sync FIFO with:
//  - true full/empty flags and an occupancy count
//  - programmable almost-full/almost-empty levels
//  - sticky overflow/underflow error flags
//  - selectable standard or first-word-fall-through (FWFT) read mode

---
 rtl/sync_fifo_prog_if.sv | 32 +++
 rtl/sync_fifo_prog.sv | 110 +++++++++++
 tb/tb_sync_fifo_prog.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_prog.
// master = the stages using the FIFO, slave = the FIFO itself.
interface sync_fifo_prog_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered level flags, programmable almost-full/empty
// thresholds, sticky overflow/underflow and standard or fall-through read.
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 4,
   parameter int FWFT       = 0
) (
   input  logic            clk,
   input  logic            rst,
   sync_fifo_prog_if.slave fifo
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  af_q;
   logic                  ae_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Acceptance looks only at the registered flags, so a pop cannot make room
   // for a same-cycle push into a full FIFO (and vice versa when empty).
   assign wr_acc = fifo.wr_en & ~full_q;
   assign rd_acc = fifo.rd_en & ~empty_q;

   always_comb begin
      count_nxt = count_q;
      if (wr_acc && !rd_acc)
         count_nxt = count_q + 1'b1;
      else if (!wr_acc && rd_acc)
         count_nxt = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_nxt;
         full_q  <= (count_nxt == CW'(DEPTH));
         empty_q <= (count_nxt == '0);
         af_q    <= (count_nxt >= CW'(AF_LEVEL));
         ae_q    <= (count_nxt <= CW'(AE_LEVEL));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr] <= fifo.wr_data;
   end

   // Error flags are sticky; a fresh error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= (fifo.wr_en & full_q)  | (overflow_q  & ~fifo.clr_err);
         underflow_q <= (fifo.rd_en & empty_q) | (underflow_q & ~fifo.clr_err);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign fifo.rd_data  = mem[rd_ptr];
         assign fifo.rd_valid = ~empty_q;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q;
         logic                  rd_valid_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem[rd_ptr];
            end
         end

         assign fifo.rd_data  = rd_data_q;
         assign fifo.rd_valid = rd_valid_q;
      end
   endgenerate

   assign fifo.count        = count_q;
   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = af_q;
   assign fifo.almost_empty = ae_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one standard-mode and one FWFT instance.
module tb_sync_fifo_prog;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_err    = 0;
   int   n_checks = 0;

   always #5 clk = ~clk;

   sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b0 ();
   sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b1 ();

   sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0))
      u_std (.clk(clk), .rst(rst), .fifo(b0));
   sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1))
      u_fwft (.clk(clk), .rst(rst), .fifo(b1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_lvl(input string tag, input int c);
      chk({tag, " count"}, 32'(b0.count), 32'(c));
      chk({tag, " full"}, 32'(b0.full), 32'(c == 16));
      chk({tag, " empty"}, 32'(b0.empty), 32'(c == 0));
      chk({tag, " almost_full"}, 32'(b0.almost_full), 32'(c >= 12));
      chk({tag, " almost_empty"}, 32'(b0.almost_empty), 32'(c <= 4));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      b0.wr_en = 0; b0.wr_data = 0; b0.rd_en = 0; b0.clr_err = 0;
      b1.wr_en = 0; b1.wr_data = 0; b1.rd_en = 0; b1.clr_err = 0;
      rst = 1;
      tick(); tick();
      rst = 0;

      // reset state
      chk_lvl("reset", 0);
      chk("reset rd_valid", 32'(b0.rd_valid), 32'd0);
      chk("reset rd_data", 32'(b0.rd_data), 32'd0);
      chk("reset overflow", 32'(b0.overflow), 32'd0);
      chk("reset underflow", 32'(b0.underflow), 32'd0);
      chk("reset fwft rd_valid", 32'(b1.rd_valid), 32'd0);

      // 1: fill with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         b0.wr_en = 1; b0.wr_data = 8'(i);
         tick();
         chk_lvl($sformatf("fill%0d", i), i);
      end
      b0.wr_en = 0;
      chk("fill overflow", 32'(b0.overflow), 32'd0);

      // 2: write while full, clr_err, set-wins, push+pop at full
      b0.wr_en = 1; b0.wr_data = 8'hAA;
      tick();
      b0.wr_en = 0;
      chk("ovf set", 32'(b0.overflow), 32'd1);
      chk_lvl("ovf", 16);
      b0.clr_err = 1;
      tick();
      b0.clr_err = 0;
      chk("ovf clear", 32'(b0.overflow), 32'd0);
      b0.clr_err = 1; b0.wr_en = 1;
      tick();
      b0.wr_en = 0;
      chk("ovf set wins", 32'(b0.overflow), 32'd1);
      tick();
      b0.clr_err = 0;
      chk("ovf clear2", 32'(b0.overflow), 32'd0);
      b0.wr_en = 1; b0.wr_data = 8'hBB; b0.rd_en = 1;
      tick();
      b0.wr_en = 0; b0.rd_en = 0;
      chk_lvl("full pushpop", 15);
      chk("full pushpop rd_valid", 32'(b0.rd_valid), 32'd1);
      chk("full pushpop rd_data", 32'(b0.rd_data), 32'h01);
      chk("full pushpop ovf", 32'(b0.overflow), 32'd1);
      b0.clr_err = 1;
      tick();
      b0.clr_err = 0;

      // 3: drain remaining 0x02..0x10
      for (int i = 2; i <= 16; i++) begin
         b0.rd_en = 1;
         tick();
         chk($sformatf("drain%0d rd_valid", i), 32'(b0.rd_valid), 32'd1);
         chk($sformatf("drain%0d rd_data", i), 32'(b0.rd_data), 32'(i));
         chk_lvl($sformatf("drain%0d", i), 16 - i);
      end
      b0.rd_en = 0;
      tick();
      chk("idle rd_valid", 32'(b0.rd_valid), 32'd0);
      chk("idle rd_data hold", 32'(b0.rd_data), 32'h10);
      chk("drain underflow", 32'(b0.underflow), 32'd0);

      // 4: count 5, then 20 cycles of push+pop across the pointer wrap
      for (int i = 0; i < 5; i++) begin
         b0.wr_en = 1; b0.wr_data = 8'(8'h20 + i);
         tick();
      end
      chk_lvl("pre-stream", 5);
      for (int k = 0; k < 20; k++) begin
         b0.wr_en = 1; b0.wr_data = 8'(8'h25 + k); b0.rd_en = 1;
         tick();
         chk($sformatf("stream%0d rd_data", k), 32'(b0.rd_data), 32'(8'h20 + k));
         chk($sformatf("stream%0d rd_valid", k), 32'(b0.rd_valid), 32'd1);
         chk($sformatf("stream%0d count", k), 32'(b0.count), 32'd5);
      end
      b0.wr_en = 0;
      for (int k = 0; k < 5; k++) begin
         b0.rd_en = 1;
         tick();
         chk($sformatf("tail%0d rd_data", k), 32'(b0.rd_data), 32'(8'h34 + k));
      end
      b0.rd_en = 0;
      chk_lvl("tail", 0);

      // 5: underflow, read+write at empty, reset mid-fill
      b0.rd_en = 1;
      tick();
      b0.rd_en = 0;
      chk("uf set", 32'(b0.underflow), 32'd1);
      chk("uf rd_valid", 32'(b0.rd_valid), 32'd0);
      chk("uf rd_data hold", 32'(b0.rd_data), 32'h38);
      chk_lvl("uf", 0);
      b0.rd_en = 1; b0.wr_en = 1; b0.wr_data = 8'h77;
      tick();
      b0.rd_en = 0; b0.wr_en = 0;
      chk_lvl("empty pushpop", 1);
      chk("empty pushpop rd_valid", 32'(b0.rd_valid), 32'd0);
      b0.clr_err = 1;
      tick();
      b0.clr_err = 0;
      chk("uf clear", 32'(b0.underflow), 32'd0);
      for (int i = 0; i < 6; i++) begin
         b0.wr_en = 1; b0.wr_data = 8'(8'h78 + i);
         tick();
      end
      b0.wr_en = 0;
      chk_lvl("mid-fill", 7);
      rst = 1;
      tick();
      rst = 0;
      chk_lvl("mid rst", 0);
      chk("mid rst rd_data", 32'(b0.rd_data), 32'd0);
      b0.wr_en = 1; b0.wr_data = 8'h99;
      tick();
      b0.wr_en = 0; b0.rd_en = 1;
      tick();
      b0.rd_en = 0;
      chk("post rst rd_data", 32'(b0.rd_data), 32'h99);
      chk_lvl("post rst", 0);

      // 6: FWFT instance
      b1.wr_en = 1; b1.wr_data = 8'h5C;
      tick();
      b1.wr_en = 0;
      chk("fwft rd_valid", 32'(b1.rd_valid), 32'd1);
      chk("fwft rd_data", 32'(b1.rd_data), 32'h5C);
      b1.rd_en = 1;
      tick();
      b1.rd_en = 0;
      chk("fwft pop rd_valid", 32'(b1.rd_valid), 32'd0);
      chk("fwft pop empty", 32'(b1.empty), 32'd1);
      b1.wr_en = 1; b1.wr_data = 8'hA1;
      tick();
      b1.wr_data = 8'hA2;
      tick();
      b1.wr_en = 0;
      chk("fwft head A1", 32'(b1.rd_data), 32'hA1);
      chk("fwft count2", 32'(b1.count), 32'd2);
      b1.rd_en = 1;
      tick();
      chk("fwft head A2", 32'(b1.rd_data), 32'hA2);
      chk("fwft valid A2", 32'(b1.rd_valid), 32'd1);
      tick();
      b1.rd_en = 0;
      chk("fwft drained", 32'(b1.rd_valid), 32'd0);
      chk("fwft no uf", 32'(b1.underflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
